// File: rtl/mem_arb_pkg.sv
// Shared types and parameter range checks for the fetch / load-store memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int MEM_LAT_MIN    = 1;
  localparam int MEM_LAT_MAX    = 7;
  localparam int STARVE_MAX_MIN = 1;
  localparam int STARVE_MAX_MAX = 15;

  function automatic bit mem_lat_ok(input int lat);
    return (lat >= MEM_LAT_MIN) && (lat <= MEM_LAT_MAX);
  endfunction

  function automatic bit starve_max_ok(input int limit);
    return (limit >= STARVE_MAX_MIN) && (limit <= STARVE_MAX_MAX);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-macro signals around the arbiter.
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        ls_req;
  logic [31:0] ls_addr;
  logic [3:0]  ls_we;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic        ls_valid;
  logic        ls_stall;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  // The arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush,
    input  ls_req, ls_addr, ls_we, ls_wdata,
    input  mem_rdata,
    output if_rdata, if_valid, if_stall,
    output ls_rdata, ls_valid, ls_stall,
    output mem_req, mem_addr, mem_we, mem_wdata
  );

  // The core requesters together with the memory macro.
  modport master (
    output if_req, if_addr, if_flush,
    output ls_req, ls_addr, ls_we, ls_wdata,
    output mem_rdata,
    input  if_rdata, if_valid, if_stall,
    input  ls_rdata, ls_valid, ls_stall,
    input  mem_req, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises fetch and load/store accesses onto one fixed-latency memory port,
// one access outstanding at a time, with fetch anti-starvation and flush kill.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rstn,
  mem_arbiter_if.slave bus
);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must be in 1..7");
  end
  if (!starve_max_ok(STARVE_MAX)) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..15");
  end

  localparam logic [2:0] LAT_LOAD   = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  owner_t      owner;
  logic [2:0]  lat_cnt;
  logic [3:0]  starve_cnt;
  logic        kill;
  logic        is_store;

  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_we_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic        if_valid_q;
  logic [31:0] ls_rdata_q;
  logic        ls_valid_q;

  logic        any_req;
  logic        fetch_wins;
  logic        flush_hit;
  logic        drop_fetch;

  assign any_req    = bus.if_req | bus.ls_req;
  // Load/store is the older instruction, so it wins unless fetch has waited too long.
  assign fetch_wins = bus.if_req & (~bus.ls_req | (starve_cnt == STARVE_LIM));
  assign flush_hit  = (state != ST_IDLE) && (owner == OWN_IF) && bus.if_flush;
  // A flush in the capture cycle itself must also suppress the response.
  assign drop_fetch = kill | flush_hit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // NOTE: the data registers are reset as well, so every output is 0 out of reset.
      state       <= ST_IDLE;
      owner       <= OWN_IF;
      lat_cnt     <= 3'd0;
      starve_cnt  <= 4'd0;
      kill        <= 1'b0;
      is_store    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_we_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      if_valid_q  <= 1'b0;
      ls_rdata_q  <= 32'd0;
      ls_valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every branch below sees pre-edge values.
      if (flush_hit) begin
        kill <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          kill <= 1'b0;
          if (!bus.if_req) begin
            starve_cnt <= 4'd0;
          end
          if (any_req) begin
            state     <= ST_ISSUE;
            mem_req_q <= 1'b1;
            lat_cnt   <= LAT_LOAD;
            if (fetch_wins) begin
              owner       <= OWN_IF;
              is_store    <= 1'b0;
              mem_addr_q  <= bus.if_addr;
              mem_we_q    <= 4'd0;
              mem_wdata_q <= 32'd0;
              starve_cnt  <= 4'd0;
            end else begin
              owner       <= OWN_LS;
              is_store    <= (bus.ls_we != 4'd0);
              mem_addr_q  <= bus.ls_addr;
              mem_we_q    <= bus.ls_we;
              mem_wdata_q <= bus.ls_wdata;
              if (bus.if_req && (starve_cnt != 4'hF)) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end
          end
        end

        ST_ISSUE: begin
          state     <= ST_WAIT;
          mem_req_q <= 1'b0;
          mem_we_q  <= 4'd0;
        end

        ST_WAIT: begin
          if (lat_cnt == 3'd0) begin
            state <= ST_RESP;
            if (owner == OWN_LS) begin
              ls_valid_q <= 1'b1;
              if (!is_store) begin
                ls_rdata_q <= bus.mem_rdata;
              end
            end else if (!drop_fetch) begin
              if_valid_q <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end

        ST_RESP: begin
          state      <= ST_IDLE;
          if_valid_q <= 1'b0;
          ls_valid_q <= 1'b0;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_stall  = bus.if_req & ~if_valid_q;

  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.ls_valid  = ls_valid_q;
  assign bus.ls_stall  = bus.ls_req & ~ls_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LAT=1/STARVE_MAX=2, one with MEM_LAT=3.
module tb_mem_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bf ();
  mem_arbiter_if bs ();

  mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(2)) u_fast (.clk(clk), .rstn(rstn), .bus(bf));
  mem_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u_slow (.clk(clk), .rstn(rstn), .bus(bs));

  logic [136:0] fast_outs;
  logic [136:0] slow_outs;
  assign fast_outs = {bf.mem_req, bf.mem_we, bf.mem_addr, bf.mem_wdata, bf.if_rdata, bf.if_valid,
                      bf.if_stall, bf.ls_rdata, bf.ls_valid, bf.ls_stall};
  assign slow_outs = {bs.mem_req, bs.mem_we, bs.mem_addr, bs.mem_wdata, bs.if_rdata, bs.if_valid,
                      bs.if_stall, bs.ls_rdata, bs.ls_valid, bs.ls_stall};

  function automatic logic [31:0] mem_model(input logic [31:0] addr);
    if (addr == 32'h0000_0100) return 32'h0000_0013;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  // Memory macros: read data is driven only in the cycle exactly MEM_LAT after mem_req.
  int          f_lat = 0;
  int          s_lat = 0;
  logic [31:0] f_pend = '0;
  logic [31:0] s_pend = '0;
  always begin
    @(negedge clk);
    if (bf.mem_req) begin f_lat = 1; f_pend = mem_model(bf.mem_addr); end
    if (bs.mem_req) begin s_lat = 3; s_pend = mem_model(bs.mem_addr); end
    @(posedge clk);
    #1;
    bf.mem_rdata = 32'hDEAD_BEEF;
    bs.mem_rdata = 32'hDEAD_BEEF;
    if (f_lat > 0) begin f_lat--; if (f_lat == 0) bf.mem_rdata = f_pend; end
    if (s_lat > 0) begin s_lat--; if (s_lat == 0) bs.mem_rdata = s_pend; end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (fast_outs !== '0) begin errors++; $display("FAIL reset_fast: got %h expected 0", fast_outs); end
    checks++;
    if (slow_outs !== '0) begin errors++; $display("FAIL reset_slow: got %h expected 0", slow_outs); end
    cyc();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({fast_outs, slow_outs} !== '0) begin
      errors++; $display("FAIL reset_release: got %h expected 0", {fast_outs, slow_outs});
    end
    cyc();
  endtask

  task automatic test_fetch();
    bf.if_req = 1'b1; bf.if_addr = 32'h100;                         // cycle 0
    @(negedge clk);
    checks++;
    if ({bf.if_stall, bf.mem_req} !== 2'b10) begin
      errors++; $display("FAIL fetch_c0 stall/mem_req: got %b expected 10", {bf.if_stall, bf.mem_req});
    end
    cyc(); @(negedge clk);                                          // cycle 1
    checks++;
    if ({bf.mem_req, bf.mem_we, bf.mem_addr, bf.if_stall} !== {1'b1, 4'h0, 32'h100, 1'b1}) begin
      errors++; $display("FAIL fetch_c1 issue: got %b %h %h %b expected 1 0 00000100 1",
                         bf.mem_req, bf.mem_we, bf.mem_addr, bf.if_stall);
    end
    cyc(); @(negedge clk);                                          // cycle 2
    checks++;
    if ({bf.mem_req, bf.if_valid, bf.if_stall} !== 3'b001) begin
      errors++; $display("FAIL fetch_c2 wait: got %b expected 001", {bf.mem_req, bf.if_valid, bf.if_stall});
    end
    cyc(); @(negedge clk);                                          // cycle 3
    checks++;
    if ({bf.if_valid, bf.if_stall, bf.ls_valid, bf.if_rdata} !== {3'b100, 32'h0000_0013}) begin
      errors++; $display("FAIL fetch_c3 resp: got %b%b%b %h expected 100 00000013",
                         bf.if_valid, bf.if_stall, bf.ls_valid, bf.if_rdata);
    end
    cyc(); bf.if_req = 1'b0;                                        // cycle 4
    @(negedge clk);
    checks++;
    if ({bf.if_valid, bf.mem_req, bf.if_rdata} !== {2'b00, 32'h0000_0013}) begin
      errors++; $display("FAIL fetch_c4 idle: got %b%b %h expected 00 00000013",
                         bf.if_valid, bf.mem_req, bf.if_rdata);
    end
    cyc();
  endtask

  task automatic test_both();
    bf.ls_req = 1'b1; bf.ls_addr = 32'h2000; bf.ls_we = 4'b0011; bf.ls_wdata = 32'hAABB_CCDD;
    bf.if_req = 1'b1; bf.if_addr = 32'h104;                         // cycle 0
    cyc(); @(negedge clk);                                          // cycle 1
    checks++;
    if ({bf.mem_req, bf.mem_we, bf.mem_addr, bf.mem_wdata} !== {1'b1, 4'b0011, 32'h2000, 32'hAABB_CCDD}) begin
      errors++; $display("FAIL both_c1 store issue: got %b %b %h %h expected 1 0011 00002000 aabbccdd",
                         bf.mem_req, bf.mem_we, bf.mem_addr, bf.mem_wdata);
    end
    checks++;
    if ({bf.if_stall, bf.ls_stall} !== 2'b11) begin
      errors++; $display("FAIL both_c1 stalls: got %b expected 11", {bf.if_stall, bf.ls_stall});
    end
    cyc(); @(negedge clk);                                          // cycle 2
    checks++;
    if ({bf.mem_req, bf.mem_we} !== 5'b0_0000) begin
      errors++; $display("FAIL both_c2 we cleared: got %b %b expected 0 0000", bf.mem_req, bf.mem_we);
    end
    cyc(); @(negedge clk);                                          // cycle 3
    checks++;
    if ({bf.ls_valid, bf.if_valid, bf.ls_stall, bf.if_stall, bf.ls_rdata} !== {4'b1001, 32'h0}) begin
      errors++; $display("FAIL both_c3 store resp: got %b%b%b%b %h expected 1001 00000000",
                         bf.ls_valid, bf.if_valid, bf.ls_stall, bf.if_stall, bf.ls_rdata);
    end
    cyc(); bf.ls_req = 1'b0; bf.ls_we = 4'b0; bf.ls_wdata = 32'h0;  // cycle 4
    @(negedge clk);
    checks++;
    if ({bf.mem_req, bf.ls_valid} !== 2'b00) begin
      errors++; $display("FAIL both_c4 idle: got %b expected 00", {bf.mem_req, bf.ls_valid});
    end
    cyc(); @(negedge clk);                                          // cycle 5
    checks++;
    if ({bf.mem_req, bf.mem_we, bf.mem_addr} !== {1'b1, 4'h0, 32'h104}) begin
      errors++; $display("FAIL both_c5 fetch issue: got %b %b %h expected 1 0000 00000104",
                         bf.mem_req, bf.mem_we, bf.mem_addr);
    end
    cyc(); cyc(); @(negedge clk);                                   // cycle 7
    checks++;
    if ({bf.if_valid, bf.if_rdata} !== {1'b1, 32'h0104_FEFB}) begin
      errors++; $display("FAIL both_c7 fetch resp: got %b %h expected 1 0104fefb", bf.if_valid, bf.if_rdata);
    end
    cyc(); bf.if_req = 1'b0;                                        // cycle 8
    cyc();
  endtask

  task automatic test_back_to_back();
    bf.ls_req = 1'b1; bf.ls_addr = 32'h40; bf.ls_we = 4'b0;         // cycle 0
    cyc(); cyc(); cyc(); @(negedge clk);                            // cycle 3
    checks++;
    if ({bf.ls_valid, bf.ls_stall, bf.ls_rdata} !== {2'b10, 32'h0040_FFBF}) begin
      errors++; $display("FAIL b2b_c3 first load: got %b%b %h expected 10 0040ffbf",
                         bf.ls_valid, bf.ls_stall, bf.ls_rdata);
    end
    cyc(); bf.ls_addr = 32'h44;                                     // cycle 4
    cyc(); @(negedge clk);                                          // cycle 5
    checks++;
    if ({bf.mem_req, bf.mem_addr, bf.ls_stall} !== {1'b1, 32'h44, 1'b1}) begin
      errors++; $display("FAIL b2b_c5 second issue: got %b %h %b expected 1 00000044 1",
                         bf.mem_req, bf.mem_addr, bf.ls_stall);
    end
    cyc(); @(negedge clk);                                          // cycle 6
    checks++;
    if (bf.ls_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_c6 early valid: got %b expected 0", bf.ls_valid);
    end
    cyc(); @(negedge clk);                                          // cycle 7
    checks++;
    if ({bf.ls_valid, bf.if_valid, bf.ls_rdata} !== {2'b10, 32'h0044_FFBB}) begin
      errors++; $display("FAIL b2b_c7 second load: got %b%b %h expected 10 0044ffbb",
                         bf.ls_valid, bf.if_valid, bf.ls_rdata);
    end
    cyc(); bf.ls_req = 1'b0;                                        // cycle 8
    cyc();
  endtask

  task automatic test_starve();
    logic [5:0] order   = '0;
    int         grants  = 0;
    int         overlap = 0;
    bf.ls_req = 1'b1; bf.ls_addr = 32'h80; bf.ls_we = 4'b0;
    bf.if_req = 1'b1; bf.if_addr = 32'h200;
    for (int n = 0; n < 60 && grants < 6; n++) begin
      @(negedge clk);
      if (bf.ls_valid && bf.if_valid) overlap++;
      if (bf.ls_valid) begin order = {order[4:0], 1'b1}; grants++; end
      else if (bf.if_valid) begin order = {order[4:0], 1'b0}; grants++; end
      cyc();
    end
    bf.ls_req = 1'b0; bf.if_req = 1'b0;
    checks++;
    if (grants !== 6) begin errors++; $display("FAIL starve_timeout: got %0d grants expected 6", grants); end
    checks++;
    if (order !== 6'b110110) begin
      errors++; $display("FAIL starve_order (1=LS): got %b expected 110110", order);
    end
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL starve_both_valid: got %0d expected 0", overlap); end
    checks++;
    if ({bf.if_rdata, bf.ls_rdata} !== {32'h0200_FDFF, 32'h0080_FF7F}) begin
      errors++; $display("FAIL starve_rdata: got %h %h expected 0200fdff 0080ff7f", bf.if_rdata, bf.ls_rdata);
    end
    cyc();
  endtask

  task automatic test_flush();
    int stale = 0;
    bs.if_req = 1'b1; bs.if_addr = 32'h300;                         // cycle 0
    cyc(); @(negedge clk);                                          // cycle 1
    checks++;
    if ({bs.mem_req, bs.mem_addr} !== {1'b1, 32'h300}) begin
      errors++; $display("FAIL flush_c1 issue: got %b %h expected 1 00000300", bs.mem_req, bs.mem_addr);
    end
    cyc(); bs.if_flush = 1'b1;                                      // cycle 2
    @(negedge clk); if (bs.if_valid) stale++;
    cyc(); bs.if_flush = 1'b0; bs.if_req = 1'b0;                    // cycle 3
    for (int c = 3; c < 6; c++) begin
      @(negedge clk); if (bs.if_valid) stale++;
      cyc();
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL flush_valid_suppressed: got %0d pulses expected 0", stale); end
    checks++;
    if (bs.if_rdata !== 32'h0) begin errors++; $display("FAIL flush_rdata: got %h expected 00000000", bs.if_rdata); end
    bs.if_req = 1'b1; bs.if_addr = 32'h304; bs.if_flush = 1'b1;     // cycle 6: idle, flush ignored
    @(negedge clk);
    checks++;
    if (bs.mem_req !== 1'b0) begin errors++; $display("FAIL flush_c6 mem_req: got %b expected 0", bs.mem_req); end
    cyc(); bs.if_flush = 1'b0;                                      // cycle 7
    @(negedge clk);
    checks++;
    if ({bs.mem_req, bs.mem_addr} !== {1'b1, 32'h304}) begin
      errors++; $display("FAIL flush_c7 reissue: got %b %h expected 1 00000304", bs.mem_req, bs.mem_addr);
    end
    cyc(); cyc(); cyc(); @(negedge clk);                            // cycle 10
    checks++;
    if (bs.if_valid !== 1'b0) begin errors++; $display("FAIL flush_c10 early valid: got %b expected 0", bs.if_valid); end
    cyc(); @(negedge clk);                                          // cycle 11
    checks++;
    if ({bs.if_valid, bs.if_rdata} !== {1'b1, 32'h0304_FCFB}) begin
      errors++; $display("FAIL flush_c11 resp: got %b %h expected 1 0304fcfb", bs.if_valid, bs.if_rdata);
    end
    cyc(); bs.if_req = 1'b0;                                        // cycle 12
    cyc();
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    bs.ls_req = 1'b1; bs.ls_addr = 32'h500; bs.ls_we = 4'b0;        // cycle 0
    cyc(); @(negedge clk);                                          // cycle 1
    checks++;
    if ({bs.mem_req, bs.mem_addr} !== {1'b1, 32'h500}) begin
      errors++; $display("FAIL rstmid_c1 issue: got %b %h expected 1 00000500", bs.mem_req, bs.mem_addr);
    end
    cyc(); cyc();                                                   // cycle 3, in WAIT
    rstn = 1'b0; bs.ls_req = 1'b0;
    #2;
    checks++;
    if ({slow_outs, fast_outs} !== '0) begin
      errors++; $display("FAIL rstmid_async_clear: got %h expected 0", {slow_outs, fast_outs});
    end
    cyc(); rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); if (bs.ls_valid || bs.mem_req) stale++;
      cyc();
    end
    checks++;
    if (stale !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d events expected 0", stale); end
    bs.ls_req = 1'b1; bs.ls_addr = 32'h504;                         // new cycle 0
    cyc(); @(negedge clk);                                          // cycle 1
    checks++;
    if ({bs.mem_req, bs.mem_addr} !== {1'b1, 32'h504}) begin
      errors++; $display("FAIL rstmid_new_issue: got %b %h expected 1 00000504", bs.mem_req, bs.mem_addr);
    end
    cyc(); cyc(); cyc(); cyc(); @(negedge clk);                     // cycle 5
    checks++;
    if ({bs.ls_valid, bs.ls_rdata} !== {1'b1, 32'h0504_FAFB}) begin
      errors++; $display("FAIL rstmid_new_resp: got %b %h expected 1 0504fafb", bs.ls_valid, bs.ls_rdata);
    end
    cyc(); bs.ls_req = 1'b0;
    cyc();
  endtask

  initial begin
    bf.if_req = 1'b0; bf.if_addr = '0; bf.if_flush = 1'b0;
    bf.ls_req = 1'b0; bf.ls_addr = '0; bf.ls_we = '0; bf.ls_wdata = '0;
    bs.if_req = 1'b0; bs.if_addr = '0; bs.if_flush = 1'b0;
    bs.ls_req = 1'b0; bs.ls_addr = '0; bs.ls_we = '0; bs.ls_wdata = '0;
    test_reset();
    test_fetch();
    test_both();
    test_back_to_back();
    test_starve();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
